// File: rtl/cache_axi_rd_arbiter.sv
// cache_axi_rd_arbiter
// Shares one AXI4 read address/data channel pair between the ICache and DCache
// miss paths. Round-robin grant, a single outstanding burst, and returned beats
// are steered combinationally to whichever cache owns the current transaction.
module cache_axi_rd_arbiter #(
    parameter int unsigned LINE_WORDS = 4,
    parameter logic [3:0]  ID_I       = 4'd0,
    parameter logic [3:0]  ID_D       = 4'd1
) (
    input  logic        clk,
    input  logic        reset,

    input  logic        i_req,
    input  logic [31:0] i_addr,
    input  logic        i_single,
    output logic        i_ack,
    output logic        i_ret_valid,
    output logic        i_ret_last,
    output logic [31:0] i_ret_data,

    input  logic        d_req,
    input  logic [31:0] d_addr,
    input  logic        d_single,
    output logic        d_ack,
    output logic        d_ret_valid,
    output logic        d_ret_last,
    output logic [31:0] d_ret_data,

    output logic        ret_err,
    output logic        proto_err,

    output logic [3:0]  arid,
    output logic [31:0] araddr,
    output logic [7:0]  arlen,
    output logic [2:0]  arsize,
    output logic [1:0]  arburst,
    output logic        arvalid,
    input  logic        arready,

    input  logic [3:0]  rid,
    input  logic [31:0] rdata,
    input  logic [1:0]  rresp,
    input  logic        rlast,
    input  logic        rvalid,
    output logic        rready
);

    // Byte span of one cache line, used to align burst start addresses.
    localparam logic [31:0] LINE_MASK = ~(32'(LINE_WORDS * 4) - 32'd1);
    localparam logic [7:0]  LINE_LEN  = 8'(LINE_WORDS - 1);

    // Owner encoding: 0 = ICache, 1 = DCache.
    localparam logic OWN_I = 1'b0;
    localparam logic OWN_D = 1'b1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_AR   = 2'd1,
        S_R    = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic        owner_q;
    logic        last_owner_q;
    logic [31:0] addr_q;
    logic        single_q;
    logic [3:0]  cnt_q;
    logic        proto_err_q;

    logic        any_req;
    logic        grant_d;
    logic        take_req;
    logic        r_beat;
    logic        beat_err;
    logic [3:0]  cur_id;
    logic [7:0]  cur_len;

    // On a tie the cache that did not own the previous burst wins.
    assign any_req  = i_req | d_req;
    assign grant_d  = (i_req && d_req) ? ~last_owner_q : d_req;
    assign take_req = (state_q == S_IDLE) && any_req;
    assign r_beat   = (state_q == S_R) && rvalid;

    assign cur_id  = (owner_q == OWN_D) ? ID_D : ID_I;
    assign cur_len = single_q ? 8'd0 : LINE_LEN;

    // A beat is malformed if rlast disagrees with the beat count or the id is foreign.
    assign beat_err = (rid != cur_id)
                    || (rlast && ({4'd0, cnt_q} != cur_len))
                    || (!rlast && ({4'd0, cnt_q} == cur_len));

    // Address channel fields come straight from the latched request, so they
    // stay constant for as long as arvalid waits on arready.
    assign arid    = cur_id;
    assign arlen   = cur_len;
    assign araddr  = single_q ? (addr_q & ~32'd3) : (addr_q & LINE_MASK);
    assign arsize  = 3'b010;
    assign arburst = 2'b01;

    assign i_ret_data = rdata;
    assign d_ret_data = rdata;
    assign proto_err  = proto_err_q;

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state: idle until a request, hold AR until accepted, stay in R until rlast.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: if (any_req)          state_d = S_AR;
            S_AR:   if (arready)          state_d = S_R;
            S_R:    if (rvalid && rlast)  state_d = S_IDLE;
            default:                      state_d = S_IDLE;
        endcase
    end

    // Outputs: arvalid/ack in AR, rready and owner-steered beat qualifiers in R.
    always_comb begin
        arvalid     = 1'b0;
        rready      = 1'b0;
        i_ack       = 1'b0;
        d_ack       = 1'b0;
        i_ret_valid = 1'b0;
        d_ret_valid = 1'b0;
        i_ret_last  = 1'b0;
        d_ret_last  = 1'b0;
        ret_err     = 1'b0;
        unique case (state_q)
            S_AR: begin
                arvalid = 1'b1;
                i_ack   = arready && (owner_q == OWN_I);
                d_ack   = arready && (owner_q == OWN_D);
            end
            S_R: begin
                rready      = 1'b1;
                i_ret_valid = rvalid && (owner_q == OWN_I);
                d_ret_valid = rvalid && (owner_q == OWN_D);
                i_ret_last  = rvalid && rlast && (owner_q == OWN_I);
                d_ret_last  = rvalid && rlast && (owner_q == OWN_D);
                ret_err     = rvalid && (rresp != 2'b00);
            end
            default: ;
        endcase
    end

    // Control state: owner selection, round-robin history, beat count, sticky error.
    always_ff @(posedge clk) begin
        if (reset) begin
            owner_q      <= OWN_I;
            last_owner_q <= OWN_I;
            cnt_q        <= 4'd0;
            proto_err_q  <= 1'b0;
        end else begin
            if (take_req) begin
                owner_q <= grant_d;
            end
            if (r_beat) begin
                if (rlast) begin
                    cnt_q        <= 4'd0;
                    last_owner_q <= owner_q;
                end else begin
                    cnt_q <= cnt_q + 4'd1;
                end
                if (beat_err) begin
                    proto_err_q <= 1'b1;
                end
            end
        end
    end

    // Request payload captured at grant; only meaningful while a burst is in flight.
    always_ff @(posedge clk) begin
        if (take_req) begin
            addr_q   <= (grant_d == OWN_D) ? d_addr : i_addr;
            single_q <= (grant_d == OWN_D) ? d_single : i_single;
        end
    end

endmodule

// File: tb/tb_cache_axi_rd_arbiter.sv
// Bench for cache_axi_rd_arbiter: two cache clients, an AXI read slave model,
// a transaction-level reference model and a scoreboard monitor.
module tb_cache_axi_rd_arbiter;

    localparam int LW = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        i_req = 1'b0, d_req = 1'b0;
    logic [31:0] i_addr = '0, d_addr = '0;
    logic        i_single = 1'b0, d_single = 1'b0;
    logic        i_ack, i_ret_valid, i_ret_last;
    logic        d_ack, d_ret_valid, d_ret_last;
    logic [31:0] i_ret_data, d_ret_data;
    logic        ret_err, proto_err;
    logic [3:0]  arid;
    logic [31:0] araddr;
    logic [7:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;
    logic        arvalid;
    logic        arready = 1'b0;
    logic [3:0]  rid = '0;
    logic [31:0] rdata = '0;
    logic [1:0]  rresp = '0;
    logic        rlast = 1'b0, rvalid = 1'b0;
    logic        rready;

    cache_axi_rd_arbiter #(.LINE_WORDS(LW), .ID_I(4'd0), .ID_D(4'd1)) dut (
        .clk(clk), .reset(reset),
        .i_req(i_req), .i_addr(i_addr), .i_single(i_single), .i_ack(i_ack),
        .i_ret_valid(i_ret_valid), .i_ret_last(i_ret_last), .i_ret_data(i_ret_data),
        .d_req(d_req), .d_addr(d_addr), .d_single(d_single), .d_ack(d_ack),
        .d_ret_valid(d_ret_valid), .d_ret_last(d_ret_last), .d_ret_data(d_ret_data),
        .ret_err(ret_err), .proto_err(proto_err),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
        .arvalid(arvalid), .arready(arready),
        .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid),
        .rready(rready)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endfunction

    function automatic void fail_missing(string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s: got an event, expected none pending (t=%0t)", name, $time);
    endfunction

    typedef struct {
        bit          own;
        logic [31:0] addr;
        logic [7:0]  len;
        logic [3:0]  id;
    } txn_t;

    typedef struct {
        bit          own;
        logic [31:0] data;
        bit          last;
        bit          err;
    } beat_t;

    typedef struct {
        logic [31:0] data;
        logic [1:0]  resp;
        bit          last;
        logic [3:0]  id;
    } sbeat_t;

    txn_t   exp_ar[$];
    txn_t   slv_q[$];
    beat_t  exp_beats[$];
    sbeat_t s_beats[$];

    // Reference model: arbitration and AR contents at transaction level.
    bit m_busy = 0, m_last = 0, m_own = 0, m_perr = 0;

    always @(negedge clk) begin
        txn_t t;
        logic [31:0] a;
        bit s;
        if (reset) begin
            m_busy = 0;
            m_last = 0;
            m_perr = 0;
        end else if (m_busy) begin
            if (rvalid && rready && rlast) begin
                m_busy = 0;
                m_last = m_own;
            end
        end else if (i_req || d_req) begin
            m_own  = (i_req && d_req) ? !m_last : d_req;
            a      = m_own ? d_addr : i_addr;
            s      = m_own ? d_single : i_single;
            t.own  = m_own;
            t.addr = s ? (a - (a % 32'd4)) : (a - (a % 32'(LW * 4)));
            t.len  = s ? 8'd0 : 8'(LW - 1);
            t.id   = m_own ? 4'd1 : 4'd0;
            exp_ar.push_back(t);
            slv_q.push_back(t);
            m_busy = 1;
        end
    end

    // Scoreboard monitor.
    int          wait_cnt = 0, last_wait = 0, d_ack_total = 0, i_beats = 0, d_beats = 0;
    bit          prev_wait = 0;
    logic [31:0] prev_addr;
    logic [7:0]  prev_len;
    logic [3:0]  prev_id;

    always @(negedge clk) begin
        txn_t  t;
        beat_t b;
        if (arvalid && prev_wait) begin
            chk("araddr_stable", araddr, prev_addr);
            chk("arlen_stable", arlen, prev_len);
            chk("arid_stable", arid, prev_id);
        end
        if (arvalid && arready) begin
            if (exp_ar.size() == 0) begin
                fail_missing("ar_unexpected");
            end else begin
                t = exp_ar.pop_front();
                chk("araddr", araddr, t.addr);
                chk("arlen", arlen, t.len);
                chk("arid", arid, t.id);
                chk("arsize", arsize, 3'b010);
                chk("arburst", arburst, 2'b01);
                chk("i_ack", i_ack, !t.own);
                chk("d_ack", d_ack, t.own);
                chk("proto_err_at_ar", proto_err, m_perr);
            end
            last_wait = wait_cnt;
            wait_cnt  = 0;
        end else begin
            chk("ack_without_handshake", {i_ack, d_ack}, 2'b00);
            if (arvalid) wait_cnt++;
        end
        if (d_ack) d_ack_total++;
        prev_wait = arvalid && !arready;
        prev_addr = araddr;
        prev_len  = arlen;
        prev_id   = arid;

        if (rvalid && rready) begin
            if (exp_beats.size() == 0) begin
                fail_missing("beat_unexpected");
            end else begin
                b = exp_beats.pop_front();
                chk("i_ret_valid", i_ret_valid, !b.own);
                chk("d_ret_valid", d_ret_valid, b.own);
                chk("ret_data", b.own ? d_ret_data : i_ret_data, b.data);
                chk("ret_last", b.own ? d_ret_last : i_ret_last, b.last);
                chk("ret_err", ret_err, b.err);
            end
        end else begin
            chk("ret_valid_idle", {i_ret_valid, d_ret_valid}, 2'b00);
        end
        if (i_ret_valid) i_beats++;
        if (d_ret_valid) d_beats++;
    end

    // AXI read slave.
    int cfg_delay = 0;
    bit cfg_rand_ar = 0;
    bit cfg_gap = 0;
    int cfg_fault = 0;
    int s_ar_cnt = -1;

    initial begin
        forever begin
            bit     ar_fire, r_fire, bad_rid;
            txn_t   t;
            sbeat_t sb;
            beat_t  eb;
            int     nb;
            @(negedge clk);
            ar_fire = arvalid && arready && !reset;
            r_fire  = rvalid && rready && !reset;
            if (arvalid && !arready && !reset && s_ar_cnt < 0) s_ar_cnt = cfg_delay - 1;
            @(posedge clk);
            #1;
            if (reset) begin
                s_beats.delete();
                rvalid   = 1'b0;
                rlast    = 1'b0;
                arready  = 1'b0;
                s_ar_cnt = -1;
            end else begin
                if (r_fire) begin
                    void'(s_beats.pop_front());
                    rvalid = 1'b0;
                end
                if (ar_fire) begin
                    s_ar_cnt = -1;
                    if (cfg_rand_ar) cfg_delay = $urandom_range(0, 3);
                    if (slv_q.size() == 0) begin
                        fail_missing("slave_ar_unexpected");
                    end else begin
                        t = slv_q.pop_front();
                        nb = int'(t.len) + 1;
                        bad_rid = 0;
                        if (cfg_fault == 1 && t.len >= 8'd2) begin
                            nb = 2;
                            m_perr = 1;
                        end
                        if (cfg_fault == 2) begin
                            bad_rid = 1;
                            m_perr = 1;
                        end
                        cfg_fault = 0;
                        for (int k = 0; k < nb; k++) begin
                            sb.data = $urandom;
                            sb.resp = 2'($urandom_range(0, 3));
                            sb.last = (k == nb - 1);
                            sb.id   = (bad_rid && k == 0) ? (t.id ^ 4'h1) : t.id;
                            s_beats.push_back(sb);
                            eb.own  = t.own;
                            eb.data = sb.data;
                            eb.last = sb.last;
                            eb.err  = (sb.resp != 2'b00);
                            exp_beats.push_back(eb);
                        end
                    end
                end
                if (s_ar_cnt < 0) begin
                    arready = (cfg_delay == 0);
                end else if (s_ar_cnt == 0) begin
                    arready = 1'b1;
                end else begin
                    s_ar_cnt--;
                    arready = 1'b0;
                end
                if (!rvalid && s_beats.size() > 0) begin
                    if (!cfg_gap || $urandom_range(0, 2) != 0) begin
                        rvalid = 1'b1;
                        rdata  = s_beats[0].data;
                        rresp  = s_beats[0].resp;
                        rlast  = s_beats[0].last;
                        rid    = s_beats[0].id;
                    end
                end
                if (!rvalid) rlast = 1'b0;
            end
        end
    end

    // One cache client request: raise req, hold until ack, wait for the last beat.
    task automatic do_req(input bit side, input logic [31:0] a, input bit single);
        bit got;
        @(posedge clk);
        #1;
        if (!side) begin i_addr = a; i_single = single; i_req = 1'b1; end
        else       begin d_addr = a; d_single = single; d_req = 1'b1; end
        got = 0;
        for (int k = 0; k < 300 && !got; k++) begin
            @(negedge clk);
            got = side ? d_ack : i_ack;
        end
        chk("ack_wait", got, 1);
        @(posedge clk);
        #1;
        if (!side) i_req = 1'b0; else d_req = 1'b0;
        if (got) begin
            got = 0;
            for (int k = 0; k < 300 && !got; k++) begin
                @(negedge clk);
                got = side ? (d_ret_valid && d_ret_last) : (i_ret_valid && i_ret_last);
            end
            chk("last_wait", got, 1);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic rand_client(input bit side, input int n);
        for (int k = 0; k < n; k++) begin
            logic [31:0] a;
            bit s;
            repeat ($urandom_range(0, 6)) @(posedge clk);
            a = $urandom;
            s = ($urandom_range(0, 3) == 0);
            if (!side && $urandom_range(0, 15) == 0) cfg_fault = s ? 2 : 1;
            do_req(side, a, s);
        end
    endtask

    task automatic do_reset(input int n);
        @(posedge clk);
        #1;
        reset = 1'b1;
        repeat (n) @(posedge clk);
        #1;
        reset = 1'b0;
        exp_ar.delete();
        slv_q.delete();
        exp_beats.delete();
    endtask

    task automatic check_quiet(input string tag);
        @(negedge clk);
        chk({tag, "_arvalid"}, arvalid, 0);
        chk({tag, "_rready"}, rready, 0);
        chk({tag, "_acks"}, {i_ack, d_ack}, 2'b00);
        chk({tag, "_ret_valid"}, {i_ret_valid, d_ret_valid}, 2'b00);
        chk({tag, "_proto_err"}, proto_err, 0);
    endtask

    initial begin
        #600000;
        $display("FAIL watchdog: got no completion, expected end of test");
        $fatal(1, "watchdog");
    end

    initial begin
        int b0, a0;
        bit got;

        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        check_quiet("reset");

        // Line fetch, arready already high.
        b0 = i_beats;
        do_req(0, 32'hbfc00384, 0);
        chk("i_beats_line", i_beats - b0, 4);

        // Simultaneous requests right after reset: DCache first, then ICache.
        do_reset(2);
        b0 = d_beats;
        a0 = i_beats;
        fork
            do_req(0, 32'h00400010, 0);
            do_req(1, 32'h80001044, 0);
        join
        chk("tie_d_beats", d_beats - b0, 4);
        chk("tie_i_beats", i_beats - a0, 4);

        // Uncached single-word read.
        b0 = d_beats;
        do_req(1, 32'h1faf0008, 1);
        chk("d_beats_single", d_beats - b0, 1);

        // arready withheld for 5 cycles.
        cfg_delay = 5;
        a0 = d_ack_total;
        do_req(1, 32'h80001230, 0);
        chk("ar_wait_cycles", last_wait, 5);
        chk("d_ack_pulses", d_ack_total - a0, 1);
        cfg_delay = 0;

        // Early rlast on the 2nd beat of a line.
        cfg_fault = 1;
        b0 = i_beats;
        do_req(0, 32'h00402000, 0);
        chk("early_last_beats", i_beats - b0, 2);
        repeat (2) @(posedge clk);
        chk("proto_err_set", proto_err, 1);
        do_req(1, 32'h80003000, 0);
        chk("proto_err_sticky", proto_err, 1);

        // Randomised traffic from both caches.
        do_reset(2);
        cfg_gap = 1;
        cfg_rand_ar = 1;
        fork
            rand_client(0, 40);
            rand_client(1, 40);
        join
        repeat (10) @(posedge clk);
        chk("exp_ar_empty", exp_ar.size(), 0);
        chk("exp_beats_empty", exp_beats.size(), 0);
        chk("proto_err_random", proto_err, m_perr);

        // Reset in the middle of a burst.
        cfg_gap = 0;
        cfg_rand_ar = 0;
        cfg_delay = 0;
        cfg_fault = 2;
        do_req(1, 32'h00002000, 1);
        repeat (2) @(posedge clk);
        chk("proto_err_rid", proto_err, 1);
        #1;
        i_addr = 32'h00001000;
        i_single = 1'b0;
        i_req = 1'b1;
        got = 0;
        for (int k = 0; k < 50 && !got; k++) begin
            @(negedge clk);
            got = i_ack;
        end
        chk("mid_ack", got, 1);
        @(posedge clk);
        #1;
        i_req = 1'b0;
        got = 0;
        for (int k = 0; k < 50 && !got; k++) begin
            @(negedge clk);
            got = i_ret_valid;
        end
        chk("mid_beat1", got, 1);
        @(posedge clk);
        #2;
        reset = 1'b1;
        @(posedge clk);
        check_quiet("mid_reset");
        @(posedge clk);
        #1;
        reset = 1'b0;
        exp_ar.delete();
        slv_q.delete();
        exp_beats.delete();
        check_quiet("after_reset");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
